// File: rtl/bram_fifo_wc.sv
// bram_fifo_wc: width-converting FWFT FIFO on one block RAM with a prefetch/skid stage
module bram_fifo_wc #(
  parameter int WRITE_WIDTH        = 64,
  parameter int READ_WIDTH         = 32,
  parameter int WRITE_DEPTH        = 512,
  parameter int RAM_LATENCY        = 3,
  parameter int ALMOST_FULL_THRESH = WRITE_DEPTH - 4,
  parameter int CW = $clog2((WRITE_WIDTH / READ_WIDTH) * (WRITE_DEPTH + RAM_LATENCY + 1)) + 1
) (
  input  logic                   core_clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WRITE_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [READ_WIDTH-1:0]  out_data,
  output logic [CW-1:0]          count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int R  = WRITE_WIDTH / READ_WIDTH;
  localparam int AW = $clog2(WRITE_DEPTH);
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam int SD = RAM_LATENCY + 1;
  localparam int PW = $clog2(SD);
  localparam int SW = $clog2(SD + 1);

  logic [WRITE_WIDTH-1:0] r_mem [WRITE_DEPTH];
  logic [WRITE_WIDTH-1:0] r_pd [RAM_LATENCY];
  logic [WRITE_WIDTH-1:0] r_sk [SD];
  logic [AW:0]            r_wr_ptr, r_rd_ptr, w_occ;
  logic [RAM_LATENCY-1:0] r_rv;
  logic [PW-1:0]          r_sk_hd, r_sk_tl;
  logic [SW-1:0]          r_sk_cnt;
  logic [LW-1:0]          r_lane;
  logic [CW-1:0]          r_count;
  logic                   r_overflow, r_underflow;
  logic                   w_full, w_push_ok, w_issue, w_pop, w_last, w_ret, w_sk_pop;
  logic [WRITE_WIDTH-1:0] w_head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == SD - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok   = push && !w_full && !flush;
  // skid slots already promised (held or in flight) cap the prefetch so the skid never overflows
  assign w_issue     = (w_occ != '0) && (int'(r_sk_cnt) + $countones(r_rv) < SD);
  assign out_valid   = r_sk_cnt != '0;
  assign w_pop       = out_valid && out_ready;
  assign w_last      = (R == 1) || (int'(r_lane) == R - 1);
  assign w_ret       = r_rv[RAM_LATENCY-1];
  assign w_sk_pop    = w_pop && w_last;
  assign w_head      = r_sk[r_sk_hd];
  assign out_data    = out_valid ? w_head[int'(r_lane) * READ_WIDTH +: READ_WIDTH] : '0;
  assign count       = r_count;
  assign empty       = r_count == '0;
  assign full        = w_full;
  assign almost_full = int'(w_occ) >= ALMOST_FULL_THRESH;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  // RAM array, read-data pipeline and skid storage: data only, validity lives in the reset block
  always_ff @(posedge core_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    r_pd[0] <= r_mem[r_rd_ptr[AW-1:0]];
    for (int i = 1; i < RAM_LATENCY; i++) r_pd[i] <= r_pd[i-1];
    if (w_ret) r_sk[r_sk_tl] <= r_pd[RAM_LATENCY-1];
  end

  // pointers, read-valid pipeline, skid bookkeeping, lane index, occupancy and sticky flags
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rv        <= '0;
      r_sk_hd     <= '0;
      r_sk_tl     <= '0;
      r_sk_cnt    <= '0;
      r_lane      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rv        <= '0;
      r_sk_hd     <= '0;
      r_sk_tl     <= '0;
      r_sk_cnt    <= '0;
      r_lane      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rv <= RAM_LATENCY'({r_rv, w_issue});
      if (w_ret) r_sk_tl <= nxt(r_sk_tl);
      if (w_sk_pop) r_sk_hd <= nxt(r_sk_hd);
      r_sk_cnt <= r_sk_cnt + SW'(w_ret) - SW'(w_sk_pop);
      if (w_pop) r_lane <= w_last ? '0 : r_lane + 1'b1;
      r_count <= r_count + (w_push_ok ? CW'(R) : CW'(0)) - CW'(w_pop);
      if (push && w_full) r_overflow <= 1'b1;
      if (out_ready && !out_valid && r_count == '0) r_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bram_fifo_wc.sv
// tb_bram_fifo_wc: randomized lane-queue scoreboard bench for bram_fifo_wc
module tb_bram_fifo_wc;
  localparam int CW = 12;

  logic          core_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic [63:0]   in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [CW-1:0] count;
  logic          empty, full, almost_full, overflow, underflow;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  bit          prev_stall = 0;
  logic [31:0] prev_d = '0;

  bram_fifo_wc dut (
    .core_clk(core_clk), .resetn(resetn), .flush(flush), .push(push), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 core_clk = ~core_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // one clock cycle: drive, sample before the edge, update the lane queue model after it
  task automatic tick(input bit p, input bit acc, input logic [63:0] d, input bit rdy, output bit v);
    logic [31:0] sd;
    push = p;
    in_data = d;
    out_ready = rdy;
    @(negedge core_clk);
    v = out_valid;
    sd = out_data;
    if (prev_stall) begin
      n_vec++;
      if (v !== 1'b1 || sd !== prev_d) begin
        n_err++;
        $display("FAIL stall_hold: valid=%b data=%h expected valid=1 data=%h", v, sd, prev_d);
      end
    end
    @(posedge core_clk);
    #1;
    if (v && rdy) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL pop_empty_model: got data=%h but model holds no lanes", sd);
      end else begin
        if (sd !== q[0]) begin
          n_err++;
          $display("FAIL pop_data: got %h expected %h", sd, q[0]);
        end
        void'(q.pop_front());
      end
    end
    if (p && acc) begin
      q.push_back(d[31:0]);
      q.push_back(d[63:32]);
    end
    prev_stall = v && !rdy;
    prev_d = sd;
    n_vec++;
    if (count !== CW'(q.size()) || empty !== (q.size() == 0)) begin
      n_err++;
      $display("FAIL count: count=%0d empty=%b expected count=%0d empty=%b", count, empty, q.size(), q.size() == 0);
    end
  endtask

  task automatic drain();
    bit v;
    int k = 0;
    while (q.size() != 0 && k < 2500) begin
      tick(0, 0, '0, 1, v);
      k++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d lanes left expected 0", q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({out_valid, out_data, count, empty, full, almost_full, overflow, underflow} !==
        {1'b0, 32'h0, CW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s: valid=%b data=%h count=%0d empty=%b full=%b af=%b ovf=%b unf=%b expected 0,0,0,1,0,0,0,0",
               tag, out_valid, out_data, count, empty, full, almost_full, overflow, underflow);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge core_clk);
    #1;
    check_reset_outputs("reset_values");
    @(negedge core_clk);
    resetn = 1'b1;
    @(posedge core_clk);
    #1;
  endtask

  task automatic test_first_word();
    push = 1'b1;
    in_data = 64'hBBBB_BBBB_AAAA_AAAA;
    @(posedge core_clk);
    #1;
    push = 1'b0;
    n_vec++;
    if (count !== CW'(2) || empty !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL first_count: count=%0d empty=%b valid=%b expected 2 0 0", count, empty, out_valid);
    end
    for (int e = 1; e <= 3; e++) begin
      @(posedge core_clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL early_valid: edge %0d valid=%b expected 0", e, out_valid);
      end
    end
    @(posedge core_clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'hAAAA_AAAA) begin
      n_err++;
      $display("FAIL first_lane: valid=%b data=%h expected 1 aaaaaaaa", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(posedge core_clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'hBBBB_BBBB || count !== CW'(1)) begin
      n_err++;
      $display("FAIL second_lane: valid=%b data=%h count=%0d expected 1 bbbbbbbb 1", out_valid, out_data, count);
    end
    @(posedge core_clk);
    #1;
    n_vec++;
    if (empty !== 1'b1 || count !== CW'(0) || out_valid !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL after_pop: empty=%b count=%0d valid=%b unf=%b expected 1 0 0 0", empty, count, out_valid, underflow);
    end
    @(posedge core_clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if (underflow !== 1'b1) begin
      n_err++;
      $display("FAIL underflow_set: unf=%b expected 1", underflow);
    end
  endtask

  task automatic test_fill_overflow();
    bit v;
    for (int i = 0; i < 511; i++) tick(1, 1, {$urandom, $urandom}, 0, v);
    repeat (8) tick(0, 0, '0, 0, v);
    n_vec++;
    if (almost_full !== 1'b0 || full !== 1'b0) begin
      n_err++;
      $display("FAIL af_below: af=%b full=%b expected 0 0 at RAM occupancy 507", almost_full, full);
    end
    tick(1, 1, {$urandom, $urandom}, 0, v);
    n_vec++;
    if (almost_full !== 1'b1 || full !== 1'b0) begin
      n_err++;
      $display("FAIL af_at: af=%b full=%b expected 1 0 at RAM occupancy 508", almost_full, full);
    end
    for (int i = 0; i < 3; i++) tick(1, 1, {$urandom, $urandom}, 0, v);
    n_vec++;
    if (full !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL not_full_511: full=%b ovf=%b expected 0 0", full, overflow);
    end
    tick(1, 1, {$urandom, $urandom}, 0, v);
    n_vec++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_512: full=%b ovf=%b expected 1 0", full, overflow);
    end
    tick(1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 0, v);
    n_vec++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: ovf=%b full=%b expected 1 1", overflow, full);
    end
    drain();
    n_vec++;
    if (full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL after_drain: full=%b af=%b ovf=%b expected 0 0 1", full, almost_full, overflow);
    end
  endtask

  task automatic test_back_to_back();
    bit v;
    for (int i = 0; i < 40; i++) begin
      tick(1, 1, {$urandom, $urandom}, 1, v);
      if (i >= 8) begin
        n_vec++;
        if (v !== 1'b1) begin
          n_err++;
          $display("FAIL steady_valid: cycle %0d valid=%b expected 1", i, v);
        end
      end
    end
    drain();
  endtask

  task automatic test_flush();
    bit v;
    tick(1, 1, {$urandom, $urandom}, 0, v);
    tick(1, 1, {$urandom, $urandom}, 0, v);
    tick(0, 0, '0, 0, v);
    flush = 1'b1;
    push = 1'b1;
    in_data = 64'h1111_2222_3333_4444;
    @(posedge core_clk);
    #1;
    flush = 1'b0;
    push = 1'b0;
    q.delete();
    prev_stall = 0;
    n_vec++;
    if (count !== CW'(0) || out_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL flush: count=%0d valid=%b ovf=%b unf=%b empty=%b expected 0 0 0 0 1",
               count, out_valid, overflow, underflow, empty);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, '0, 0, v);
      n_vec++;
      if (v !== 1'b0) begin
        n_err++;
        $display("FAIL flush_stale: cycle %0d valid=%b expected 0", i, v);
      end
    end
  endtask

  task automatic test_random(input int cycles);
    bit v;
    bit p;
    for (int i = 0; i < cycles; i++) begin
      p = ($urandom_range(1, 0) == 1) && (q.size() < 900);
      tick(p, 1, {$urandom, $urandom}, $urandom_range(3, 0) != 0, v);
    end
    drain();
  endtask

  task automatic test_midreset();
    bit v;
    for (int i = 0; i < 6; i++) tick(1, 1, {$urandom, $urandom}, $urandom_range(1, 0) == 1, v);
    repeat (4) tick(0, 0, '0, 0, v);
    push = 1'b1;
    in_data = {$urandom, $urandom};
    #3;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    push = 1'b0;
    #2;
    resetn = 1'b1;
    q.delete();
    prev_stall = 0;
    @(posedge core_clk);
    #1;
    check_reset_outputs("post_reset");
    test_random(300);
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill_overflow();
    test_back_to_back();
    test_flush();
    test_random(2000);
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
